// File: rtl/amstrad_mem_responder.sv
// Memory-side responder: serves CPU byte accesses and video word fetches from one shared
// 16-bit RAM over a req/ack handshake, with video priority and a transaction timeout.
module amstrad_mem_responder #(
   parameter logic [21:0] VID_BASE = 22'h000000,
   parameter int unsigned TIMEOUT  = 255,
   parameter int unsigned TO_W     = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [22:0] mem_addr,
   input  logic [7:0]  mem_dout,
   input  logic        mem_rd,
   input  logic        mem_wr,
   output logic [7:0]  mem_din,
   output logic        cpu_busy,
   input  logic [14:0] vram_addr,
   input  logic        vid_strobe,
   output logic [15:0] vram_din,
   output logic [21:0] ram_addr,
   output logic [15:0] ram_wdata,
   output logic [1:0]  ram_be,
   output logic        ram_we,
   output logic        ram_req,
   input  logic        ram_ack,
   input  logic [15:0] ram_rdata,
   output logic        timeout
);

   typedef enum logic [1:0] {StIdle, StVid, StCpu} state_e;

   localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT - 1);

   state_e            state_q, state_d;
   logic              rdwr_prev_q, rdwr_prev_d;
   logic              cpu_pend_q, cpu_pend_d;
   logic [22:0]       cpu_addr_q, cpu_addr_d;
   logic [7:0]        cpu_data_q, cpu_data_d;
   logic              cpu_wr_q, cpu_wr_d;
   logic              vid_pend_q, vid_pend_d;
   logic [14:0]       vid_addr_q, vid_addr_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic [7:0]        mem_din_q, mem_din_d;
   logic [15:0]       vram_din_q, vram_din_d;
   logic [21:0]       ram_addr_q, ram_addr_d;
   logic [15:0]       ram_wdata_q, ram_wdata_d;
   logic [1:0]        ram_be_q, ram_be_d;
   logic              ram_we_q, ram_we_d;
   logic              ram_req_q, ram_req_d;
   logic              timeout_q, timeout_d;

   logic              rdwr;
   logic              cpu_start;
   logic              cpu_done;
   logic              vid_done;

   assign cpu_busy = cpu_pend_q | (state_q == StCpu);

   // Request capture; a CPU edge arriving while busy is dropped, not queued.
   always_comb begin
      rdwr        = mem_rd | mem_wr;
      cpu_start   = rdwr & ~rdwr_prev_q & ~cpu_busy;
      rdwr_prev_d = rdwr;

      cpu_pend_d  = cpu_start | (cpu_pend_q & ~cpu_done);
      cpu_addr_d  = cpu_start ? mem_addr : cpu_addr_q;
      cpu_data_d  = cpu_start ? mem_dout : cpu_data_q;
      cpu_wr_d    = cpu_start ? mem_wr   : cpu_wr_q;

      vid_pend_d  = vid_strobe | (vid_pend_q & ~vid_done);
      vid_addr_d  = vid_strobe ? vram_addr : vid_addr_q;
   end

   always_comb begin
      state_d     = state_q;
      to_cnt_d    = to_cnt_q;
      mem_din_d   = mem_din_q;
      vram_din_d  = vram_din_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      ram_be_d    = ram_be_q;
      ram_we_d    = ram_we_q;
      ram_req_d   = ram_req_q;
      timeout_d   = timeout_q;
      cpu_done    = 1'b0;
      vid_done    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (vid_pend_q) begin
               state_d     = StVid;
               to_cnt_d    = '0;
               ram_req_d   = 1'b1;
               ram_we_d    = 1'b0;
               ram_be_d    = 2'b11;
               ram_wdata_d = 16'h0000;
               ram_addr_d  = VID_BASE + {7'd0, vid_addr_q};
            end else if (cpu_pend_q) begin
               state_d     = StCpu;
               to_cnt_d    = '0;
               ram_req_d   = 1'b1;
               ram_we_d    = cpu_wr_q;
               ram_be_d    = cpu_addr_q[0] ? 2'b10 : 2'b01;
               ram_wdata_d = {cpu_data_q, cpu_data_q};
               ram_addr_d  = cpu_addr_q[22:1];
            end
         end
         StVid, StCpu: begin
            if (ram_ack) begin
               state_d   = StIdle;
               ram_req_d = 1'b0;
               if (state_q == StVid) begin
                  vid_done   = 1'b1;
                  vram_din_d = ram_rdata;
               end else begin
                  cpu_done = 1'b1;
                  if (!cpu_wr_q) begin
                     mem_din_d = cpu_addr_q[0] ? ram_rdata[15:8] : ram_rdata[7:0];
                  end
               end
            end else if (to_cnt_q == ToLast) begin
               // Abort: read-data outputs are left untouched.
               state_d   = StIdle;
               ram_req_d = 1'b0;
               timeout_d = 1'b1;
               vid_done  = (state_q == StVid);
               cpu_done  = (state_q == StCpu);
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d   = StIdle;
            ram_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         rdwr_prev_q <= 1'b0;
         cpu_pend_q  <= 1'b0;
         cpu_addr_q  <= '0;
         cpu_data_q  <= '0;
         cpu_wr_q    <= 1'b0;
         vid_pend_q  <= 1'b0;
         vid_addr_q  <= '0;
         to_cnt_q    <= '0;
         mem_din_q   <= '0;
         vram_din_q  <= '0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         ram_be_q    <= '0;
         ram_we_q    <= 1'b0;
         ram_req_q   <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rdwr_prev_q <= rdwr_prev_d;
         cpu_pend_q  <= cpu_pend_d;
         cpu_addr_q  <= cpu_addr_d;
         cpu_data_q  <= cpu_data_d;
         cpu_wr_q    <= cpu_wr_d;
         vid_pend_q  <= vid_pend_d;
         vid_addr_q  <= vid_addr_d;
         to_cnt_q    <= to_cnt_d;
         mem_din_q   <= mem_din_d;
         vram_din_q  <= vram_din_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         ram_be_q    <= ram_be_d;
         ram_we_q    <= ram_we_d;
         ram_req_q   <= ram_req_d;
         timeout_q   <= timeout_d;
      end
   end

   assign mem_din   = mem_din_q;
   assign vram_din  = vram_din_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign ram_be    = ram_be_q;
   assign ram_we    = ram_we_q;
   assign ram_req   = ram_req_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_amstrad_mem_responder.sv
// Bench for amstrad_mem_responder: rule-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_amstrad_mem_responder;

   localparam logic [21:0] VB  = 22'h3FF000;
   localparam int          TMO = 255;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [22:0] mem_addr = '0;
   logic [7:0]  mem_dout = '0;
   logic        mem_rd = 1'b0;
   logic        mem_wr = 1'b0;
   logic [7:0]  mem_din;
   logic        cpu_busy;
   logic [14:0] vram_addr = '0;
   logic        vid_strobe = 1'b0;
   logic [15:0] vram_din;
   logic [21:0] ram_addr;
   logic [15:0] ram_wdata;
   logic [1:0]  ram_be;
   logic        ram_we;
   logic        ram_req;
   logic        ram_ack;
   logic [15:0] ram_rdata;
   logic        timeout;

   amstrad_mem_responder #(
      .VID_BASE (VB),
      .TIMEOUT  (TMO),
      .TO_W     (8)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .mem_addr   (mem_addr),
      .mem_dout   (mem_dout),
      .mem_rd     (mem_rd),
      .mem_wr     (mem_wr),
      .mem_din    (mem_din),
      .cpu_busy   (cpu_busy),
      .vram_addr  (vram_addr),
      .vid_strobe (vid_strobe),
      .vram_din   (vram_din),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_be     (ram_be),
      .ram_we     (ram_we),
      .ram_req    (ram_req),
      .ram_ack    (ram_ack),
      .ram_rdata  (ram_rdata),
      .timeout    (timeout)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   int n_txn = 0;
   logic req_seen = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // RAM side: ack ack_delay cycles into a request (0 = never), or forced.
   logic        ack_force = 1'b1;
   int          ack_delay = 0;
   logic [15:0] rdata_val = '0;
   int          age_r = 0;

   initial begin
      ram_ack   = ack_force;
      ram_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         if (ram_req === 1'b1) age_r++;
         else age_r = 0;
         ram_ack   = ack_force || (ram_req === 1'b1 && ack_delay > 0 && age_r == ack_delay);
         ram_rdata = rdata_val;
      end
   end

   // Reference model: who owns the RAM, how long it has waited, what each requester asked for.
   localparam int OwnNone = 0, OwnVid = 1, OwnCpu = 2;
   int          m_owner = OwnNone;
   int          m_age = 0;
   logic        m_prev = 0, m_cpu_pend = 0, m_cpu_wr = 0, m_vid_pend = 0;
   logic [22:0] m_cpu_addr = '0;
   logic [7:0]  m_cpu_data = '0;
   logic [14:0] m_vid_addr = '0;
   logic [7:0]  m_mem_din = '0;
   logic [15:0] m_vram_din = '0;
   logic        m_timeout = 0, m_req = 0, m_we = 0;
   logic [21:0] m_addr = '0;
   logic [1:0]  m_be = '0;
   logic [15:0] m_wdata = '0;

   task automatic model_step();
      logic was_busy, edge_now, act;
      if (!reset_n) begin
         m_owner = OwnNone; m_age = 0; m_prev = 0; m_cpu_pend = 0; m_cpu_wr = 0;
         m_vid_pend = 0; m_cpu_addr = '0; m_cpu_data = '0; m_vid_addr = '0;
         m_mem_din = '0; m_vram_din = '0; m_timeout = 0; m_req = 0; m_we = 0;
         m_addr = '0; m_be = '0; m_wdata = '0;
         return;
      end
      act      = mem_rd || mem_wr;
      was_busy = m_cpu_pend;
      edge_now = act && !m_prev;
      m_prev   = act;
      if (m_owner != OwnNone) begin
         if (ram_ack) begin
            if (m_owner == OwnVid) begin
               m_vram_din = ram_rdata;
               m_vid_pend = 0;
            end else begin
               if (!m_cpu_wr) m_mem_din = m_cpu_addr[0] ? ram_rdata[15:8] : ram_rdata[7:0];
               m_cpu_pend = 0;
            end
            m_owner = OwnNone;
            m_req   = 0;
         end else begin
            m_age++;
            if (m_age == TMO) begin
               if (m_owner == OwnVid) m_vid_pend = 0;
               else m_cpu_pend = 0;
               m_timeout = 1;
               m_owner   = OwnNone;
               m_req     = 0;
            end
         end
      end else if (m_vid_pend) begin
         m_owner = OwnVid; m_age = 0; m_req = 1; m_we = 0; m_be = 2'b11;
         m_addr  = VB + {7'd0, m_vid_addr};
      end else if (m_cpu_pend) begin
         m_owner = OwnCpu; m_age = 0; m_req = 1; m_we = m_cpu_wr;
         m_be    = m_cpu_addr[0] ? 2'b10 : 2'b01;
         m_addr  = m_cpu_addr[22:1];
         m_wdata = {m_cpu_data, m_cpu_data};
      end
      if (vid_strobe) begin
         m_vid_pend = 1;
         m_vid_addr = vram_addr;
      end
      if (edge_now && !was_busy) begin
         m_cpu_pend = 1;
         m_cpu_addr = mem_addr;
         m_cpu_data = mem_dout;
         m_cpu_wr   = mem_wr;
      end
   endtask

   // Inputs change only just after posedge, so at negedge they are what the next edge samples.
   always @(negedge clk) begin
      chk("ram_req", {31'd0, ram_req}, {31'd0, m_req});
      chk("cpu_busy", {31'd0, cpu_busy}, {31'd0, m_cpu_pend});
      chk("mem_din", {24'd0, mem_din}, {24'd0, m_mem_din});
      chk("vram_din", {16'd0, vram_din}, {16'd0, m_vram_din});
      chk("timeout", {31'd0, timeout}, {31'd0, m_timeout});
      if (m_req) begin
         chk("ram_addr", {10'd0, ram_addr}, {10'd0, m_addr});
         chk("ram_be", {30'd0, ram_be}, {30'd0, m_be});
         chk("ram_we", {31'd0, ram_we}, {31'd0, m_we});
         if (m_we) chk("ram_wdata", {16'd0, ram_wdata}, {16'd0, m_wdata});
      end
      if (ram_req === 1'b1 && !req_seen) n_txn++;
      req_seen = (ram_req === 1'b1);
      model_step();
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
      $fatal(1);
   end

   initial begin
      int n0;
      int cnt;

      // Reset held with ram_ack asserted.
      tick(4);
      chk("rst_req", {31'd0, ram_req}, 32'd0);
      chk("rst_busy", {31'd0, cpu_busy}, 32'd0);
      chk("rst_mem_din", {24'd0, mem_din}, 32'd0);
      chk("rst_vram_din", {16'd0, vram_din}, 32'd0);
      chk("rst_timeout", {31'd0, timeout}, 32'd0);
      chk("rst_addr", {10'd0, ram_addr}, 32'd0);
      chk("rst_be_we", {29'd0, ram_be, ram_we}, 32'd0);
      chk("rst_wdata", {16'd0, ram_wdata}, 32'd0);
      ack_force = 1'b0;
      reset_n   = 1'b1;
      tick(2);

      // CPU read at odd address, ack three cycles into the request.
      mem_addr = 23'h00_4001; rdata_val = 16'hA55A; ack_delay = 3; mem_rd = 1'b1;
      tick(1);
      chk("rd_busy_early", {31'd0, cpu_busy}, 32'd1);
      chk("rd_req_early", {31'd0, ram_req}, 32'd0);
      tick(1);
      chk("rd_req", {31'd0, ram_req}, 32'd1);
      chk("rd_addr", {10'd0, ram_addr}, 32'h002000);
      chk("rd_be", {30'd0, ram_be}, 32'd2);
      chk("rd_we", {31'd0, ram_we}, 32'd0);
      tick(3);
      chk("rd_mem_din", {24'd0, mem_din}, 32'hA5);
      chk("rd_busy_done", {31'd0, cpu_busy}, 32'd0);
      chk("rd_req_done", {31'd0, ram_req}, 32'd0);
      mem_rd = 1'b0;
      tick(2);

      // Video strobe and CPU write start together; video first, base wraps.
      vram_addr = 15'h1234; vid_strobe = 1'b1;
      mem_addr = 23'h00_0101; mem_dout = 8'h3C; mem_wr = 1'b1;
      rdata_val = 16'hBEEF; ack_delay = 2;
      tick(1);
      vid_strobe = 1'b0;
      tick(1);
      chk("vid_addr", {10'd0, ram_addr}, 32'h000234);
      chk("vid_be_we", {29'd0, ram_be, ram_we}, 32'b110);
      tick(2);
      chk("vid_din", {16'd0, vram_din}, 32'hBEEF);
      chk("vid_then_busy", {31'd0, cpu_busy}, 32'd1);
      tick(1);
      chk("wr_addr", {10'd0, ram_addr}, 32'h000080);
      chk("wr_be_we", {29'd0, ram_be, ram_we}, 32'b101);
      chk("wr_wdata", {16'd0, ram_wdata}, 32'h3C3C);
      tick(2);
      chk("wr_busy_done", {31'd0, cpu_busy}, 32'd0);
      chk("wr_mem_din_kept", {24'd0, mem_din}, 32'hA5);
      mem_wr = 1'b0;
      tick(2);

      // Held read level: exactly one transaction.
      mem_addr = 23'h00_0200; rdata_val = 16'h1357; ack_delay = 1;
      n0 = n_txn;
      mem_rd = 1'b1;
      tick(50);
      chk("held_txn_count", n_txn - n0, 32'd1);
      chk("held_mem_din", {24'd0, mem_din}, 32'h57);
      mem_rd = 1'b0;
      tick(2);

      // No ack: abort after TIMEOUT cycles of request.
      mem_addr = 23'h00_0003; ack_delay = 0; mem_rd = 1'b1;
      tick(2);
      chk("to_req_up", {31'd0, ram_req}, 32'd1);
      cnt = 0;
      while (ram_req === 1'b1 && cnt < 300) begin
         cnt++;
         tick(1);
      end
      chk("to_req_len", cnt, 32'd255);
      chk("to_flag", {31'd0, timeout}, 32'd1);
      chk("to_mem_din", {24'd0, mem_din}, 32'h57);
      chk("to_busy", {31'd0, cpu_busy}, 32'd0);
      mem_rd = 1'b0;
      tick(2);

      // Access after a timeout still works; the flag stays set.
      mem_addr = 23'h00_0002; rdata_val = 16'h2468; ack_delay = 1; mem_rd = 1'b1;
      tick(4);
      chk("post_to_mem_din", {24'd0, mem_din}, 32'h68);
      chk("post_to_flag", {31'd0, timeout}, 32'd1);
      mem_rd = 1'b0;
      tick(2);

      // Reset mid-transaction, then a stray ack.
      mem_addr = 23'h00_0010; ack_delay = 0; mem_rd = 1'b1;
      tick(3);
      chk("mid_req_up", {31'd0, ram_req}, 32'd1);
      reset_n = 1'b0; mem_rd = 1'b0;
      tick(1);
      chk("mid_req_drop", {31'd0, ram_req}, 32'd0);
      chk("mid_busy", {31'd0, cpu_busy}, 32'd0);
      chk("mid_timeout_clr", {31'd0, timeout}, 32'd0);
      chk("mid_mem_din_clr", {24'd0, mem_din}, 32'd0);
      reset_n = 1'b1; rdata_val = 16'hFFFF; ack_force = 1'b1;
      tick(1);
      ack_force = 1'b0;
      tick(2);
      chk("late_ack_mem_din", {24'd0, mem_din}, 32'd0);
      chk("late_ack_vram_din", {16'd0, vram_din}, 32'd0);
      chk("late_ack_req", {31'd0, ram_req}, 32'd0);
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
